hbi_de_int_rcv: RTL and testbench



---
 rtl/hbi_pkg.sv | 20 ++
 rtl/hbi_tog_sync.sv | 30 +++
 rtl/hbi_de_int_rcv.sv | 145 ++++++++++++++
 tb/tb_hbi_de_int_rcv.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hbi_pkg.sv
// Shared constants for the host-bus interrupt receiver: register map,
// status bit positions and the arming FSM state type.
package hbi_pkg;

    localparam logic [1:0] HBI_A_STAT = 2'd0;
    localparam logic [1:0] HBI_A_MASK = 2'd1;
    localparam logic [1:0] HBI_A_CNT  = 2'd2;
    localparam logic [1:0] HBI_A_RSVD = 2'd3;

    localparam int HBI_ST_CLIP     = 0;
    localparam int HBI_ST_DD       = 1;
    localparam int HBI_ST_CLIP_OVR = 8;
    localparam int HBI_ST_DD_OVR   = 9;

    typedef enum logic {
        ARM_DISARMED = 1'b0,
        ARM_ARMED    = 1'b1
    } arm_state_t;

endpackage

// File: rtl/hbi_tog_sync.sv
// Toggle synchronizer: STAGES-flop chain into hb_clk, previous-value flop,
// and an edge event that is suppressed until the receiver is armed.
module hbi_tog_sync #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tog,
    input  logic armed,
    output logic ev
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // prev always follows the synchronized value, so while disarmed it
    // silently absorbs whatever level the toggle was left at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], tog};
            prev  <= chain[STAGES-1];
        end
    end

    assign ev = armed & (chain[STAGES-1] ^ prev);

endmodule

// File: rtl/hbi_de_int_rcv.sv
// Host-bus receiver for drawing-engine toggle interrupts: sync, W1C status,
// mask and registered hb_int. Optional event counters under HBI_INT_EVCNT_EN.
module hbi_de_int_rcv
    import hbi_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int CNT_W       = 8
) (
    input  logic        hb_clk,
    input  logic        hb_rstn,
    input  logic        de_clint_tog,
    input  logic        de_ddint_tog,
    input  logic        hb_wr,
    input  logic [1:0]  hb_addr,
    input  logic [31:0] hb_wdat,
    output logic [31:0] hb_rdat,
    output logic        hb_int,
    output logic [3:0]  probe_int
);

    arm_state_t state, state_nxt;
    logic [2:0] arm_cnt, arm_cnt_nxt;
    logic       armed;
    logic       ev_clip, ev_dd;
    logic [1:0] ev;
    logic [1:0] stat, ovr, mask;
    logic [1:0] stat_clr, ovr_clr;
    logic       stat_wr;
    logic [31:0] cnt_rd;

    always_ff @(posedge hb_clk or negedge hb_rstn) begin
        if (!hb_rstn) begin
            state   <= ARM_DISARMED;
            arm_cnt <= '0;
        end else begin
            state   <= state_nxt;
            arm_cnt <= arm_cnt_nxt;
        end
    end

    // Wait long enough for the sync chains and prev flops to settle on the
    // current toggle levels before letting edges through.
    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        case (state)
            ARM_DISARMED: begin
                if (arm_cnt == 3'(SYNC_STAGES)) begin
                    state_nxt = ARM_ARMED;
                end else begin
                    arm_cnt_nxt = arm_cnt + 3'd1;
                end
            end
            ARM_ARMED: state_nxt = ARM_ARMED;
            default:   state_nxt = ARM_DISARMED;
        endcase
    end

    assign armed = (state == ARM_ARMED);

    hbi_tog_sync #(.STAGES(SYNC_STAGES)) u_sync_clip (
        .clk   (hb_clk),
        .rst_n (hb_rstn),
        .tog   (de_clint_tog),
        .armed (armed),
        .ev    (ev_clip)
    );

    hbi_tog_sync #(.STAGES(SYNC_STAGES)) u_sync_dd (
        .clk   (hb_clk),
        .rst_n (hb_rstn),
        .tog   (de_ddint_tog),
        .armed (armed),
        .ev    (ev_dd)
    );

    assign ev       = {ev_dd, ev_clip};
    assign stat_wr  = hb_wr && (hb_addr == HBI_A_STAT);
    assign stat_clr = stat_wr ? hb_wdat[HBI_ST_DD:HBI_ST_CLIP] : 2'b00;
    assign ovr_clr  = stat_wr ? hb_wdat[HBI_ST_DD_OVR:HBI_ST_CLIP_OVR] : 2'b00;

    // A new event beats a same-cycle clear; overrun only counts when the
    // bit was already set and is not being cleared right now.
    always_ff @(posedge hb_clk or negedge hb_rstn) begin
        if (!hb_rstn) begin
            stat   <= '0;
            ovr    <= '0;
            mask   <= '0;
            hb_int <= 1'b0;
        end else begin
            stat   <= (stat & ~stat_clr) | ev;
            ovr    <= (ovr & ~ovr_clr) | (ev & stat & ~stat_clr);
            if (hb_wr && (hb_addr == HBI_A_MASK)) begin
                mask <= hb_wdat[1:0];
            end
            hb_int <= |(stat & mask);
        end
    end

`ifdef HBI_INT_EVCNT_EN
    logic [CNT_W-1:0] clip_cnt, dd_cnt;
    logic             cnt_wr;

    assign cnt_wr = hb_wr && (hb_addr == HBI_A_CNT);

    always_ff @(posedge hb_clk or negedge hb_rstn) begin
        if (!hb_rstn) begin
            clip_cnt <= '0;
            dd_cnt   <= '0;
        end else if (cnt_wr) begin
            clip_cnt <= CNT_W'(ev_clip);
            dd_cnt   <= CNT_W'(ev_dd);
        end else begin
            if (ev_clip && (clip_cnt != '1)) clip_cnt <= clip_cnt + CNT_W'(1);
            if (ev_dd && (dd_cnt != '1))     dd_cnt   <= dd_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        cnt_rd               = '0;
        cnt_rd[CNT_W-1:0]    = clip_cnt;
        cnt_rd[16 +: CNT_W]  = dd_cnt;
    end
`else
    assign cnt_rd = '0;
`endif

    always_comb begin
        hb_rdat = '0;
        case (hb_addr)
            HBI_A_STAT: begin
                hb_rdat[HBI_ST_CLIP]     = stat[0];
                hb_rdat[HBI_ST_DD]       = stat[1];
                hb_rdat[HBI_ST_CLIP_OVR] = ovr[0];
                hb_rdat[HBI_ST_DD_OVR]   = ovr[1];
            end
            HBI_A_MASK: hb_rdat[1:0] = mask;
            HBI_A_CNT:  hb_rdat = cnt_rd;
            default:    hb_rdat = '0;
        endcase
    end

    assign probe_int = {armed, ev_dd, ev_clip, hb_int};

endmodule

// File: tb/tb_hbi_de_int_rcv.sv
// Directed self-checking bench for hbi_de_int_rcv (SYNC_STAGES=3, CNT_W=2).
module tb_hbi_de_int_rcv;

    logic        hb_clk;
    logic        hb_rstn;
    logic        de_clint_tog;
    logic        de_ddint_tog;
    logic        hb_wr;
    logic [1:0]  hb_addr;
    logic [31:0] hb_wdat;
    logic [31:0] hb_rdat;
    logic        hb_int;
    logic [3:0]  probe_int;

    int total;
    int passed;
    logic [31:0] rd;

    hbi_de_int_rcv #(.SYNC_STAGES(3), .CNT_W(2)) dut (
        .hb_clk       (hb_clk),
        .hb_rstn      (hb_rstn),
        .de_clint_tog (de_clint_tog),
        .de_ddint_tog (de_ddint_tog),
        .hb_wr        (hb_wr),
        .hb_addr      (hb_addr),
        .hb_wdat      (hb_wdat),
        .hb_rdat      (hb_rdat),
        .hb_int       (hb_int),
        .probe_int    (probe_int)
    );

    initial hb_clk = 1'b0;
    always #5 hb_clk = ~hb_clk;

    // one active edge, ending on the following falling edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge hb_clk);
            @(negedge hb_clk);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        hb_wr   = 1'b1;
        hb_addr = a;
        hb_wdat = d;
        tick(1);
        hb_wr   = 1'b0;
        hb_wdat = '0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        hb_addr = a;
        #1;
        d = hb_rdat;
    endtask

    task automatic test_reset();
        hb_rstn = 1'b0;
        de_clint_tog = 1'b1;
        de_ddint_tog = 1'b0;
        hb_wr = 1'b0;
        hb_addr = 2'd0;
        hb_wdat = '0;
        tick(2);
        hb_rstn = 1'b1;
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL reset_status got %h exp %h", rd, 32'h0); else passed++;
        total++; if (hb_int !== 1'b0) $display("[TB] FAIL reset_hb_int got %b exp 0", hb_int); else passed++;
        tick(3);
        total++; if (probe_int[3] !== 1'b0) $display("[TB] FAIL armed_early got %b exp 0", probe_int[3]); else passed++;
        tick(1);
        total++; if (probe_int[3] !== 1'b1) $display("[TB] FAIL armed got %b exp 1", probe_int[3]); else passed++;
        tick(4);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL held_tog_status got %h exp %h", rd, 32'h0); else passed++;
        read_reg(2'd1, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL reset_mask got %h exp %h", rd, 32'h0); else passed++;
        total++; if (hb_int !== 1'b0) $display("[TB] FAIL held_tog_hb_int got %b exp 0", hb_int); else passed++;
    endtask

    task automatic test_dd_event();
        write_reg(2'd1, 32'h3);
        hb_addr = 2'd0;
        de_ddint_tog = ~de_ddint_tog;
        tick(3);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL dd_edge3_status got %h exp %h", rd, 32'h0); else passed++;
        tick(1);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h2) $display("[TB] FAIL dd_edge4_status got %h exp %h", rd, 32'h2); else passed++;
        total++; if (hb_int !== 1'b0) $display("[TB] FAIL dd_edge4_hb_int got %b exp 0", hb_int); else passed++;
        tick(1);
        total++; if (hb_int !== 1'b1) $display("[TB] FAIL dd_edge5_hb_int got %b exp 1", hb_int); else passed++;
        write_reg(2'd0, 32'h2);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL dd_w1c_status got %h exp %h", rd, 32'h0); else passed++;
        total++; if (hb_int !== 1'b1) $display("[TB] FAIL dd_w1c_hb_int_k got %b exp 1", hb_int); else passed++;
        tick(1);
        total++; if (hb_int !== 1'b0) $display("[TB] FAIL dd_w1c_hb_int_k1 got %b exp 0", hb_int); else passed++;
    endtask

    task automatic test_mask_gating();
        write_reg(2'd1, 32'h0);
        de_clint_tog = ~de_clint_tog;
        tick(6);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h1) $display("[TB] FAIL masked_status got %h exp %h", rd, 32'h1); else passed++;
        total++; if (hb_int !== 1'b0) $display("[TB] FAIL masked_hb_int got %b exp 0", hb_int); else passed++;
        write_reg(2'd1, 32'h1);
        total++; if (hb_int !== 1'b0) $display("[TB] FAIL unmask_hb_int_k got %b exp 0", hb_int); else passed++;
        tick(1);
        total++; if (hb_int !== 1'b1) $display("[TB] FAIL unmask_hb_int_k1 got %b exp 1", hb_int); else passed++;
        write_reg(2'd0, 32'h1);
        tick(1);
        total++; if (hb_int !== 1'b0) $display("[TB] FAIL clip_clear_hb_int got %b exp 0", hb_int); else passed++;
    endtask

    task automatic test_overrun();
        de_clint_tog = ~de_clint_tog;
        tick(6);
        de_clint_tog = ~de_clint_tog;
        tick(6);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h101) $display("[TB] FAIL overrun_status got %h exp %h", rd, 32'h101); else passed++;
        total++; if (hb_int !== 1'b1) $display("[TB] FAIL overrun_hb_int got %b exp 1", hb_int); else passed++;
        write_reg(2'd0, 32'h100);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h1) $display("[TB] FAIL overrun_w1c got %h exp %h", rd, 32'h1); else passed++;
    endtask

    task automatic test_coincident();
        // status bit0 is still 1 from the overrun scenario
        de_clint_tog = ~de_clint_tog;
        tick(3);
        total++; if (probe_int[1] !== 1'b1) $display("[TB] FAIL coinc_ev_clip got %b exp 1", probe_int[1]); else passed++;
        write_reg(2'd0, 32'h1);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h1) $display("[TB] FAIL coinc_status got %h exp %h", rd, 32'h1); else passed++;
        tick(1);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h1) $display("[TB] FAIL coinc_status_after got %h exp %h", rd, 32'h1); else passed++;
        write_reg(2'd0, 32'h303);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL coinc_clear got %h exp %h", rd, 32'h0); else passed++;
    endtask

    task automatic test_reserved_and_mask_bits();
        write_reg(2'd1, 32'hFFFF_FFFF);
        read_reg(2'd1, rd);
        total++; if (rd !== 32'h3) $display("[TB] FAIL mask_width got %h exp %h", rd, 32'h3); else passed++;
        write_reg(2'd3, 32'hFFFF_FFFF);
        read_reg(2'd3, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL reserved_read got %h exp %h", rd, 32'h0); else passed++;
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL reserved_no_side_effect got %h exp %h", rd, 32'h0); else passed++;
    endtask

    task automatic test_counters();
        write_reg(2'd2, 32'h0);
`ifdef HBI_INT_EVCNT_EN
        read_reg(2'd2, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL cnt_clear_init got %h exp %h", rd, 32'h0); else passed++;
        for (int i = 0; i < 5; i++) begin
            de_clint_tog = ~de_clint_tog;
            tick(6);
        end
        read_reg(2'd2, rd);
        total++; if (rd !== 32'h3) $display("[TB] FAIL cnt_saturate got %h exp %h", rd, 32'h3); else passed++;
        de_ddint_tog = ~de_ddint_tog;
        tick(6);
        read_reg(2'd2, rd);
        total++; if (rd !== 32'h0001_0003) $display("[TB] FAIL cnt_dd got %h exp %h", rd, 32'h0001_0003); else passed++;
        write_reg(2'd2, 32'h0);
        read_reg(2'd2, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL cnt_clear got %h exp %h", rd, 32'h0); else passed++;
`else
        de_clint_tog = ~de_clint_tog;
        tick(6);
        read_reg(2'd2, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL cnt_disabled_read got %h exp %h", rd, 32'h0); else passed++;
`endif
        write_reg(2'd0, 32'h303);
    endtask

    task automatic test_reset_mid();
        write_reg(2'd1, 32'h3);
        de_ddint_tog = ~de_ddint_tog;
        tick(6);
        total++; if (hb_int !== 1'b1) $display("[TB] FAIL pre_reset_hb_int got %b exp 1", hb_int); else passed++;
        #2;
        hb_rstn = 1'b0;
        #1;
        total++; if (hb_int !== 1'b0) $display("[TB] FAIL async_reset_hb_int got %b exp 0", hb_int); else passed++;
        total++; if (probe_int[3] !== 1'b0) $display("[TB] FAIL async_reset_armed got %b exp 0", probe_int[3]); else passed++;
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL async_reset_status got %h exp %h", rd, 32'h0); else passed++;
        read_reg(2'd1, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL async_reset_mask got %h exp %h", rd, 32'h0); else passed++;
        @(negedge hb_clk);
        hb_rstn = 1'b1;
        tick(4);
        total++; if (probe_int[3] !== 1'b1) $display("[TB] FAIL rearm got %b exp 1", probe_int[3]); else passed++;
        tick(2);
        read_reg(2'd0, rd);
        total++; if (rd !== 32'h0) $display("[TB] FAIL rearm_no_event got %h exp %h", rd, 32'h0); else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_dd_event();
        test_mask_gating();
        test_overrun();
        test_coincident();
        test_reserved_and_mask_bits();
        test_counters();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
